serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing A − B for two WIDTH-bit operands loaded in parallel.
- One full-subtractor cell is reused over WIDTH cycles, producing a WIDTH-bit difference and a borrow-out.
- It is the inverse-direction counterpart of the team's adder cells: a small, area-cheap arithmetic block driven by a start/ready/done handshake.

Parameters:
- WIDTH, 8, operand and difference width in bits (≥1).

Ports:
- clk    input   1      single clock, rising edge
- rst_n  input   1      reset, asynchronous, active-low
- start  input   1      request; sampled only while ready=1
- a      input   WIDTH  minuend, captured on the accepting edge
- b      input   WIDTH  subtrahend, captured on the accepting edge
- ready  output  1      high only in IDLE
- diff   output  WIDTH  registered result; holds until the next result is written
- bout   output  1      registered borrow-out (1 when a < b unsigned)
- done   output  1      one-cycle pulse; diff and bout are valid while it is high

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values (held while rst_n=0, and on any assertion mid-operation):
  - state=IDLE, ready=1, done=0, diff=0, bout=0.
  - Internal shift registers, bit counter and borrow register are cleared.
- Reset takes effect immediately; any partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: ready=1. On start=1 at a clock edge:
    - load a and b into the operand shift registers;
    - clear the borrow register and bit counter;
    - go to SHIFT.
  - SHIFT: each edge processes one bit.
    - a0, b0 are the operand register LSBs; br is the borrow register.
    - Difference bit d = a0 ^ b0 ^ br.
    - Next borrow = (~a0 & b0) | (~(a0 ^ b0) & br).
    - d is shifted into the MSB of the result shift register; the operand registers shift right.
    - The counter increments.
    - On the edge where counter == WIDTH−1, go to DONE and write the completed result into diff and the final borrow into bout in that same edge.
  - DONE: done=1 and ready=0 for exactly one cycle, then IDLE.
- Latency: accepting edge at cycle 0 → done high in the cycle after edge WIDTH.
  - That gives WIDTH cycles from capture to done, and WIDTH+2 cycles between accepts with start held high.
- start is ignored in SHIFT and DONE. Operand changes after capture have no effect.
- diff and bout change only on entry to DONE or on reset. They hold across IDLE and SHIFT.
- Counter width is $clog2(WIDTH+1), so WIDTH=1 works: one SHIFT edge, then DONE.
- Unsigned modulo arithmetic: diff = (a − b) mod 2^WIDTH; bout = (a < b).
- done is a decode of the state register, not a separate flop.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), registered alongside diff.
  - ovf = signed two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Computed as the borrow into the MSB XOR the borrow out of the MSB, captured on the final SHIFT edge.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - the counter-width helper function.
- Natural sub-module: full_subtractor_bit.
  - Combinational; inputs x, y, bin; outputs d, bo.
  - Instantiated once and reused every SHIFT cycle.

Test Plan (WIDTH=8):
- Reset: drive rst_n=0 with random inputs → ready=1, done=0, diff=8'h00, bout=0; remains so for 3 cycles after release with start=0.
- Basic: a=200, b=55, start pulse → done high exactly 8 cycles after the capture edge; diff=8'h91 (145), bout=0; ready returns the next cycle.
- Borrow: a=5, b=10 → diff=8'hFB, bout=1; with SERIAL_SUB_OVF_EN, ovf=0.
- Overflow: a=8'h80, b=8'h01 → diff=8'h7F, bout=0; with SERIAL_SUB_OVF_EN, ovf=1. Also a=b=8'hFF → diff=0, bout=0, ovf=0.
- Handshake:
  - Hold start=1 continuously with operand pairs (9,3) then (3,9): second pair captured only when ready=1; results 8'h06/bout=0, then 8'hFA/bout=1; accepts spaced 10 cycles.
  - Changing a/b during SHIFT does not alter the result.
- Mid-operation reset: pull rst_n low during the 4th SHIFT cycle → outputs zero immediately, no done pulse. Next op a=100, b=1 → diff=99, bout=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared state encoding and sizing helper for the bit-serial subtractor.
package serial_sub_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Bit-counter width able to hold 0..w, so w=1 still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return int'($clog2(w + 1));
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, bo = borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial subtractor computing a - b over WIDTH cycles with start/ready/done.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             d_c;
  logic             bo_c;
  logic [WIDTH:0]   shifted_c;
  logic             last_c;

  full_subtractor_bit u_fs (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (br_q),
    .d   (d_c),
    .bo  (bo_c)
  );

  // New difference bit enters at the MSB; upper WIDTH bits are the next result.
  assign shifted_c = {d_c, res_q};
  assign last_c    = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

  // Datapath next values: load on accept, one bit per SHIFT edge, publish on the last.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (state_q == S_IDLE && start) begin
      a_d   = a;
      b_d   = b;
      res_d = '0;
      cnt_d = '0;
      br_d  = 1'b0;
    end else if (state_q == S_SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = shifted_c[WIDTH:1];
      cnt_d = cnt_q + CW'(1);
      br_d  = bo_c;
      if (last_c) begin
        diff_d = shifted_c[WIDTH:1];
        bout_d = bo_c;
`ifdef SERIAL_SUB_OVF_EN
        // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
        ovf_d  = br_q ^ bo_c;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

endmodule
